// File: rtl/simon_arb_pkg.sv
// simon_arb_pkg: shared state encoding, default widths and operand types for the SIMON core arbiter
package simon_arb_pkg;
  localparam int SIMON_N = 16;
  localparam int SIMON_M = 4;
  typedef logic [1:0][SIMON_N-1:0] block_t;
  typedef logic [SIMON_M-1:0][SIMON_N-1:0] key_t;
  typedef enum logic [2:0] {IDLE, KEY_REQ, KEY_WAIT, DATA_REQ, DATA_WAIT, RESP} arb_state_t;
endpackage

// File: rtl/simon_rr_picker.sv
// simon_rr_picker: combinational round-robin select, scanning upward from last_grant+1 with wrap
module simon_rr_picker #(
  parameter int NREQ = 2,
  parameter int IDW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            req_any
);
  logic [IDW-1:0] p;
  assign req_any = |req;
  always_comb begin
    grant = '0;
    idx = '0;
    p = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      p = IDW'((int'(last_grant) + 1 + k) % NREQ);
      if (req[p]) begin
        grant = '0;
        grant[p] = 1'b1;
        idx = p;
      end
    end
  end
endmodule

// File: rtl/simon_arbiter.sv
// simon_arbiter: round-robin sharing of one SIMON_3264 core; SIMON_ARB_KEYCACHE_EN skips re-expansion of a repeated key
module simon_arbiter
  import simon_arb_pkg::*;
#(
  parameter int N = SIMON_N,
  parameter int M = SIMON_M,
  parameter int NREQ = 2,
  parameter int IDW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic                          clk,
  input  logic                          nR,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ-1:0][M-1:0][N-1:0] req_key,
  input  logic [NREQ-1:0][1:0][N-1:0]   req_data,
  input  logic [NREQ-1:0]               req_enc_dec,
  output logic [NREQ-1:0]               resp_valid,
  input  logic [NREQ-1:0]               resp_ready,
  output logic [1:0][N-1:0]             resp_data,
  output logic                          core_newKey,
  output logic                          core_newData,
  output logic                          core_readData,
  output logic [M-1:0][N-1:0]           core_key,
  output logic [1:0][N-1:0]             core_inData,
  output logic                          core_enc_dec,
  input  logic                          core_loadKey,
  input  logic                          core_loadData,
  input  logic                          core_doneKey,
  input  logic                          core_doneData,
  input  logic [1:0][N-1:0]             core_outData,
  output logic                          busy
);
  arb_state_t state;
  logic [IDW-1:0] id, last_grant, sel;
  logic [NREQ-1:0] grant;
  logic req_any, hit;

  simon_rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req(req_valid),
    .last_grant(last_grant),
    .grant(grant),
    .idx(sel),
    .req_any(req_any)
  );

`ifdef SIMON_ARB_KEYCACHE_EN
  logic [M-1:0][N-1:0] cache_key;
  logic cache_valid;
  assign hit = cache_valid && req_key[sel] == cache_key;
  always_ff @(posedge clk) begin
    if (nR) begin
      cache_valid <= 1'b0;
      cache_key <= '0;
    end else if (state == KEY_WAIT && core_doneKey) begin
      cache_valid <= 1'b1;
      cache_key <= core_key;
    end
  end
`else
  assign hit = 1'b0;
`endif

  // the grant pulse is the accept handshake, so it must never fire on a reset edge
  assign req_ready = (state == IDLE && !nR) ? grant : '0;
  assign resp_valid = state == RESP ? NREQ'(1) << id : '0;
  assign core_newKey = state == KEY_REQ;
  assign core_newData = state == DATA_REQ;
  assign busy = state != IDLE;

  always_ff @(posedge clk) begin
    if (nR) begin
      state <= IDLE;
      id <= '0;
      last_grant <= '0;
      core_key <= '0;
      core_inData <= '0;
      core_enc_dec <= 1'b0;
      resp_data <= '0;
      core_readData <= 1'b0;
    end else begin
      core_readData <= 1'b0;
      case (state)
        IDLE: if (req_any) begin
          state <= hit ? DATA_REQ : KEY_REQ;
          id <= sel;
          core_key <= req_key[sel];
          core_inData <= req_data[sel];
          core_enc_dec <= req_enc_dec[sel];
        end
        KEY_REQ: if (core_loadKey) state <= KEY_WAIT;
        KEY_WAIT: if (core_doneKey) state <= DATA_REQ;
        DATA_REQ: if (core_loadData) state <= DATA_WAIT;
        DATA_WAIT: if (core_doneData) begin
          state <= RESP;
          resp_data <= core_outData;
          core_readData <= 1'b1;
        end
        RESP: if (resp_ready[id]) begin
          state <= IDLE;
          last_grant <= id;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_simon_arbiter.sv
// tb_simon_arbiter: randomized and directed bench with a transaction-level reference model and a behavioural SIMON 32/64 core
module tb_simon_arbiter;
`ifdef SIMON_ARB_KEYCACHE_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif
  localparam logic [63:0] K = 64'h1918_1110_0908_0100;

  logic clk = 1'b0;
  logic nR;
  logic [1:0] req_valid, req_ready, req_enc_dec, resp_valid, resp_ready;
  logic [1:0][3:0][15:0] req_key;
  logic [1:0][1:0][15:0] req_data;
  logic [1:0][15:0] resp_data, core_inData, core_outData;
  logic [3:0][15:0] core_key;
  logic core_newKey, core_newData, core_readData, core_enc_dec, busy;
  logic core_loadKey, core_loadData, core_doneKey, core_doneData;

  simon_arbiter dut (
    .clk(clk), .nR(nR), .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
    .req_data(req_data), .req_enc_dec(req_enc_dec), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .core_newKey(core_newKey), .core_newData(core_newData),
    .core_readData(core_readData), .core_key(core_key), .core_inData(core_inData),
    .core_enc_dec(core_enc_dec), .core_loadKey(core_loadKey), .core_loadData(core_loadData),
    .core_doneKey(core_doneKey), .core_doneData(core_doneData), .core_outData(core_outData), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  int checks = 0, errors = 0;

  function automatic void chk(input string nm, input logic [159:0] a, input logic [159:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, a, e, $time);
    end
  endfunction

  function automatic logic [15:0] rol(input logic [15:0] v, input int s);
    return (v << s) | (v >> (16 - s));
  endfunction

  function automatic logic [15:0] f(input logic [15:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  function automatic logic [31:0] simon(input logic [63:0] key, input logic [31:0] blk, input logic enc);
    logic [15:0] k [32];
    logic [15:0] x, y, t;
    logic [61:0] z;
    z = 62'b11111010001001010110000111001101111101000100101011000011100110;
    for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      t = rol(k[i-1], 13) ^ k[i-3];
      t = t ^ rol(t, 15);
      k[i] = ~k[i-4] ^ t ^ {15'b0, z[61-(i-4)]} ^ 16'd3;
    end
    x = blk[31:16];
    y = blk[15:0];
    if (enc) for (int r = 0; r < 32; r++) begin
      t = x; x = y ^ f(x) ^ k[r]; y = t;
    end else for (int r = 31; r >= 0; r--) begin
      t = y; y = x ^ f(y) ^ k[r]; x = t;
    end
    return {x, y};
  endfunction

  function automatic int pick(input logic [1:0] r, input int last);
    for (int k = 1; k <= 2; k++) if (r[(last + k) % 2]) return (last + k) % 2;
    return 0;
  endfunction

  // behavioural core: random handshake latencies, spurious status on the wrong phase
  int cst = 0, cnt = 0, key_loads = 0;
  logic gen_dk = 1'b0;
  logic [63:0] ck;
  logic [31:0] cd;
  logic cen;
  initial begin
    {core_loadKey, core_loadData, core_doneKey, core_doneData} = 4'b0;
    core_outData = '0;
    forever begin
      @(posedge clk);
      #2;
      {core_loadKey, core_loadData, core_doneKey, core_doneData} = 4'b0;
      gen_dk = 1'b0;
      if (nR) cst = 0;
      else case (cst)
        0: if (core_newKey) begin cnt = $urandom_range(0, 3); cst = 1; end
           else if (core_newData) begin cnt = $urandom_range(0, 3); cst = 3; end
        1: if (cnt > 0) cnt--;
           else begin core_loadKey = 1'b1; ck = core_key; key_loads++; cnt = $urandom_range(1, 5); cst = 2; end
        2: if (cnt > 0) begin cnt--; core_loadData = 1'($urandom_range(0, 1)); end
           else begin core_doneKey = 1'b1; gen_dk = 1'b1; cst = 0; end
        3: if (cnt > 0) cnt--;
           else begin core_loadData = 1'b1; cd = core_inData; cen = core_enc_dec; cnt = $urandom_range(1, 5); cst = 4; end
        4: if (cnt > 0) begin cnt--; core_doneKey = 1'($urandom_range(0, 1)); end
           else begin core_doneData = 1'b1; core_outData = simon(ck, cd, cen); cst = 0; end
        default: cst = 0;
      endcase
    end
  end

  // transaction-level reference model, compared every cycle
  logic en = 1'b0;
  logic m_busy = 0, m_resp = 0, m_rd = 0, m_need = 0, m_cvalid = 0, m_enc = 0;
  logic [0:0] m_id = 0, m_last = 0, pk;
  logic [63:0] m_key, m_ckey;
  logic [31:0] m_data, m_exp;
  logic [1:0] er, rr_seen = 0;
  int gq[$];
  always @(negedge clk) if (en) begin
    er = 2'b0;
    pk = 1'(pick(req_valid, int'(m_last)));
    if (!m_busy && !nR && req_valid != 2'b0) er = 2'(1) << pk;
    chk("req_ready", req_ready, er);
    chk("busy", busy, m_busy);
    chk("resp_valid", resp_valid, m_resp ? 2'(1) << m_id : 2'b0);
    chk("readData", core_readData, m_rd);
    if (m_resp) chk("resp_data", resp_data, m_exp);
    if (core_newKey) begin
      chk("newKey_phase", m_busy && m_need && !m_resp, 1);
      chk("core_key", core_key, m_key);
    end
    if (core_newData) begin
      chk("newData_phase", m_busy && !m_need && !m_resp, 1);
      chk("core_in", {core_enc_dec, core_inData}, {m_enc, m_data});
    end
    rr_seen = req_ready;
    if (nR) begin
      m_busy = 0; m_resp = 0; m_rd = 0; m_last = 0; m_cvalid = 0; m_need = 0;
    end else begin
      if (m_resp && resp_ready[m_id]) begin m_resp = 0; m_busy = 0; m_last = m_id; end
      m_rd = 0;
      if (core_doneData && m_busy) begin m_resp = 1; m_rd = 1; end
      if (gen_dk) begin m_need = 0; m_cvalid = 1; m_ckey = m_key; end
      if (er != 2'b0) begin
        m_busy = 1; m_id = pk; m_key = req_key[pk]; m_data = req_data[pk]; m_enc = req_enc_dec[pk];
        m_exp = simon(m_key, m_data, m_enc);
        m_need = !(CE && m_cvalid && m_ckey == m_key);
        gq.push_back(int'(pk));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 nR = 1'b1;
    @(posedge clk); #1 nR = 1'b0;
  endtask

  task automatic wait_idle();
    logic ok = 1'b0;
    for (int c = 0; c < 500 && !ok; c++) begin @(negedge clk); ok = !busy; end
    chk("reach_idle", ok, 1);
  endtask

  task automatic run_one(input int r, input logic [63:0] key, input logic [31:0] dat, input logic enc,
                         output logic [31:0] res, output int kl);
    logic ok;
    int k0;
    @(posedge clk); #1;
    k0 = key_loads;
    resp_ready = 2'b11;
    req_valid[r] = 1'b1; req_key[r] = key; req_data[r] = dat; req_enc_dec[r] = enc;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin @(negedge clk); ok = req_ready[r]; end
    chk("grant", ok, 1);
    @(posedge clk); #1 req_valid[r] = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin @(negedge clk); ok = resp_valid[r]; end
    chk("resp_seen", ok, 1);
    res = resp_data;
    kl = key_loads - k0;
  endtask

  logic [63:0] kp [4];
  logic [31:0] res, held;
  int kl;
  logic ok;
  initial begin
    nR = 1'b1; req_valid = '0; req_key = '0; req_data = '0; req_enc_dec = '0; resp_ready = '0;
    kp[0] = K;
    for (int i = 1; i < 4; i++) kp[i] = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {req_ready, resp_valid, resp_data, core_newKey, core_newData, core_readData,
                          core_key, core_inData, core_enc_dec, busy}, 0);
    @(posedge clk); #1 nR = 1'b0; en = 1'b1;
    chk("pin_model", simon(K, 32'h6565_6877, 1'b1), 32'hc69b_e9bb);

    run_one(0, K, 32'h6565_6877, 1'b1, res, kl);
    chk("enc_result", res, 32'hc69b_e9bb);
    chk("enc_keyloads", kl, 1);
    run_one(1, K, 32'hc69b_e9bb, 1'b0, res, kl);
    chk("dec_result", res, 32'h6565_6877);
    chk("dec_keyloads", kl, CE ? 0 : 1);
    run_one(0, 64'h0123_4567_89ab_cdef, 32'h1234_5678, 1'b1, res, kl);
    chk("newkey_result", res, simon(64'h0123_4567_89ab_cdef, 32'h1234_5678, 1'b1));
    chk("newkey_keyloads", kl, 1);
    wait_idle();

    do_reset();
    gq.delete();
    resp_ready = 2'b11;
    req_valid = 2'b11;
    req_key[0] = kp[1]; req_key[1] = kp[2];
    for (int c = 0; c < 2000 && gq.size() < 4; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) if (rr_seen[i]) req_data[i] = $urandom;
    end
    req_valid = 2'b0;
    chk("alt_count", gq.size() >= 4, 1);
    for (int i = 0; i < 4 && i < gq.size(); i++) chk("alt_order", gq[i], (i % 2 == 0) ? 1 : 0);
    wait_idle();

    @(posedge clk); #1;
    resp_ready = 2'b10;
    req_valid[0] = 1'b1; req_key[0] = K; req_data[0] = 32'h6565_6877; req_enc_dec[0] = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin @(negedge clk); ok = req_ready[0]; end
    chk("bp_grant", ok, 1);
    @(posedge clk); #1 req_valid = 2'b10;
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin @(negedge clk); ok = resp_valid[0]; end
    chk("bp_resp", ok, 1);
    held = resp_data;
    chk("bp_data", held, 32'hc69b_e9bb);
    repeat (10) begin
      @(negedge clk);
      chk("bp_hold", {resp_valid, resp_data, busy, req_ready}, {2'b01, held, 1'b1, 2'b00});
    end
    @(posedge clk); #1 resp_ready = 2'b11;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin @(negedge clk); ok = req_ready[1]; end
    chk("bp_next_grant", ok, 1);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_idle();

    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_key[0] = K; req_data[0] = 32'h6565_6877; req_enc_dec[0] = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin @(negedge clk); ok = req_ready[0]; end
    @(posedge clk); #1 req_valid[0] = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin @(negedge clk); ok = cst == 4; end
    chk("reach_data_wait", ok, 1);
    do_reset();
    @(negedge clk);
    chk("midop_reset_outputs", {req_ready, resp_valid, resp_data, core_newKey, core_newData, core_readData,
                                core_key, core_inData, core_enc_dec, busy}, 0);
    run_one(0, K, 32'h6565_6877, 1'b1, res, kl);
    chk("post_reset_result", res, 32'hc69b_e9bb);
    chk("post_reset_keyloads", kl, 1);
    wait_idle();

    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      resp_ready = 2'($urandom);
      for (int i = 0; i < 2; i++) begin
        if (rr_seen[i] || (req_valid[i] && $urandom_range(0, 19) == 0)) req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_key[i] = kp[$urandom_range(0, 3)];
          req_data[i] = $urandom;
          req_enc_dec[i] = 1'($urandom_range(0, 1));
        end
      end
      nR = $urandom_range(0, 499) == 0;
    end
    @(posedge clk); #1;
    nR = 1'b0; req_valid = 2'b0; resp_ready = 2'b11;
    wait_idle();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog: got timeout want finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
